// File: rtl/pad_slice8_dir_ctrl.sv
// -----------------------------------------------------------------------------
// pad_slice8_dir_ctrl
//   Direction/drive sequencer for one 8-pad slice: 4 input-only pads and
//   4 bidirectional pads. The bidir pads are the ones whose bit is set in
//   BidirMask.
//   One-pad commands arrive over a valid/ready handshake. The block sequences
//   out/oe/ie per pad with break-before-make turnaround: oe and ie are never
//   both high on a pad. It also returns a synchronized, glitch-filtered copy
//   of the pad inputs to the core, together with a per-pad change pulse.
//
// Optional feature macro: PAD_SLICE8_LOCK_EN
//   When defined, this macro adds lock_i[7:0]. A command to a locked pad is
//   accepted, has no effect, and pulses cmd_err_o. lock_i is sampled at
//   accept only.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous reset, active low
//   cmd_valid_i  command valid
//   cmd_ready_o  high only while idle; a command is taken on valid & ready
//   cmd_pad_i    target pad index
//   cmd_oe_i     1 = output mode, 0 = input mode
//   cmd_out_i    drive value (used when cmd_oe_i = 1)
//   cmd_err_o    1-cycle pulse: the accepted command was rejected
//   lock_i       per-pad command lock (PAD_SLICE8_LOCK_EN only)
//   out_o        per-pad drive value      -> slice out_i
//   oe_o         per-pad output enable    -> slice oe_i
//   ie_o         per-pad input enable     -> slice ie_i
//   in_raw_i     raw pad input, asynchronous <- slice in_raw_o
//   in_filt_o    synchronized, filtered pad input
//   in_chg_o     1-cycle pulse per pad when in_filt_o changes
// -----------------------------------------------------------------------------
module pad_slice8_dir_ctrl #(
  parameter logic [7:0]  BidirMask  = 8'h0F,
  parameter int unsigned TurnCycles = 2,   // 1..15
  parameter int unsigned FiltCycles = 4    // 1..15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_pad_i,
  input  logic       cmd_oe_i,
  input  logic       cmd_out_i,
  output logic       cmd_err_o,
`ifdef PAD_SLICE8_LOCK_EN
  input  logic [7:0] lock_i,
`endif
  output logic [7:0] out_o,
  output logic [7:0] oe_o,
  output logic [7:0] ie_o,
  input  logic [7:0] in_raw_i,
  output logic [7:0] in_filt_o,
  output logic [7:0] in_chg_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [3:0] TurnLoad = 4'(TurnCycles);
  localparam logic [3:0] FiltLast = 4'(FiltCycles - 1);

  // ---------------------------------------------------------------------------
  // Direction sequencer
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [2:0] pad_q, pad_d;      // pad being sequenced in SETUP/TURN
  logic [3:0] cnt_q, cnt_d;      // turnaround countdown
  logic [7:0] out_q, out_d;
  logic [7:0] oe_q, oe_d;
  logic [7:0] ie_q, ie_d;
  logic       err_q, err_d;
  logic       accept;
  logic       locked;

  assign cmd_ready_o = (state_q == IDLE);
  assign accept      = cmd_valid_i & cmd_ready_o;

`ifdef PAD_SLICE8_LOCK_EN
  assign locked = lock_i[cmd_pad_i];
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first. A path that
    // leaves a signal unassigned would infer a latch.
    state_d = state_q;
    pad_d   = pad_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    oe_d    = oe_q;
    ie_d    = ie_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (locked || (cmd_oe_i && !BidirMask[cmd_pad_i])) begin
            err_d = 1'b1;
          end else if (cmd_oe_i && oe_q[cmd_pad_i]) begin
            // Pad is already driving: update the value in place.
            out_d[cmd_pad_i] = cmd_out_i;
          end else if (cmd_oe_i) begin
            // Input -> output: drop ie and settle out one cycle before oe.
            ie_d[cmd_pad_i]  = 1'b0;
            out_d[cmd_pad_i] = cmd_out_i;
            pad_d            = cmd_pad_i;
            state_d          = SETUP;
          end else if (oe_q[cmd_pad_i]) begin
            // Output -> input: drop oe, keep ie low for TurnCycles cycles.
            oe_d[cmd_pad_i] = 1'b0;
            cnt_d           = TurnLoad;
            pad_d           = cmd_pad_i;
            state_d         = TURN;
          end
          // Input request to a pad that is already an input: no-op.
        end
      end

      SETUP: begin
        oe_d[pad_q] = 1'b1;
        state_d     = IDLE;
      end

      TURN: begin
        if (cnt_q <= 4'd1) begin
          ie_d[pad_q] = 1'b1;
          cnt_d       = 4'd0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state always uses non-blocking (<=) assignments, so
      // every register samples values from before the clock edge.
      state_q <= IDLE;
      pad_q   <= 3'd0;
      cnt_q   <= 4'd0;
      out_q   <= 8'h00;
      oe_q    <= 8'h00;
      ie_q    <= 8'hFF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      ie_q    <= ie_d;
      err_q   <= err_d;
    end
  end

  assign out_o     = out_q;
  assign oe_o      = oe_q;
  assign ie_o      = ie_q;
  assign cmd_err_o = err_q;

  // ---------------------------------------------------------------------------
  // Input path: 2-FF synchronizer, then a per-pad stability filter
  // ---------------------------------------------------------------------------
  logic [7:0]      sync1_q, sync_q;
  logic [7:0]      filt_q, chg_q;
  logic [7:0][3:0] fcnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 8'h00;
      sync_q  <= 8'h00;
    end else begin
      sync1_q <= in_raw_i;
      sync_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the filter counters are few and feed control decisions, so the
      // whole array is reset rather than left to power-up values.
      filt_q <= 8'h00;
      chg_q  <= 8'h00;
      fcnt_q <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        chg_q[k] <= 1'b0;
        if (!ie_q[k] || (sync_q[k] == filt_q[k])) begin
          // Disabled pads hold their filtered value; agreement restarts the count.
          fcnt_q[k] <= 4'd0;
        end else if (fcnt_q[k] >= FiltLast) begin
          // This sample is the FiltCycles-th consecutive disagreement.
          filt_q[k] <= sync_q[k];
          chg_q[k]  <= 1'b1;
          fcnt_q[k] <= 4'd0;
        end else begin
          fcnt_q[k] <= fcnt_q[k] + 4'd1;
        end
      end
    end
  end

  assign in_filt_o = filt_q;
  assign in_chg_o  = chg_q;

endmodule

// File: tb/tb_pad_slice8_dir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pad_slice8_dir_ctrl
//   Scoreboard bench for pad_slice8_dir_ctrl with the default parameters
//   (BidirMask=0F, TurnCycles=2, FiltCycles=4).
//   The stimulus process drives directed commands and pad inputs. For each
//   one it queues hand-computed expectations, each tagged with the cycle in
//   which it must hold.
//   A monitor samples the DUT on every falling edge. It pops and compares
//   queued pad/handshake states, cmd_err_o pulses and in_chg_o pulses.
//   It also checks the oe/ie invariants on every cycle.
// -----------------------------------------------------------------------------
module tb_pad_slice8_dir_ctrl;

  logic       clk;
  logic       rst_ni;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_pad;
  logic       cmd_oe;
  logic       cmd_out;
  logic       cmd_err;
  logic [7:0] lock;
  logic [7:0] out_v, oe_v, ie_v;
  logic [7:0] in_raw, in_filt, in_chg;

  pad_slice8_dir_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_pad_i   (cmd_pad),
    .cmd_oe_i    (cmd_oe),
    .cmd_out_i   (cmd_out),
    .cmd_err_o   (cmd_err),
`ifdef PAD_SLICE8_LOCK_EN
    .lock_i      (lock),
`endif
    .out_o       (out_v),
    .oe_o        (oe_v),
    .ie_o        (ie_v),
    .in_raw_i    (in_raw),
    .in_filt_o   (in_filt),
    .in_chg_o    (in_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         at;
    string      name;
    logic       rdy;
    logic [7:0] out;
    logic [7:0] oe;
    logic [7:0] ie;
    logic [7:0] filt;
  } exp_t;

  typedef struct {
    int         at;
    logic [7:0] val;
  } chg_t;

  exp_t exp_q[$];
  chg_t chg_q[$];
  int   err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_state(input int at, input string name, input logic rdy,
                              input logic [7:0] o, input logic [7:0] e,
                              input logic [7:0] i, input logic [7:0] f);
    exp_t x;
    x.at = at; x.name = name; x.rdy = rdy; x.out = o; x.oe = e; x.ie = i; x.filt = f;
    exp_q.push_back(x);
  endtask

  task automatic expect_chg(input int at, input logic [7:0] v);
    chg_t c;
    c.at = at; c.val = v;
    chg_q.push_back(c);
  endtask

  task automatic drive(input logic [2:0] p, input logic oe, input logic o);
    cmd_valid = 1'b1;
    cmd_pad   = p;
    cmd_oe    = oe;
    cmd_out   = o;
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    logic       err_exp;
    logic [7:0] chg_exp;

    check("oe_and_ie", 32'(oe_v & ie_v), 32'h0);
    check("oe_non_bidir", 32'(oe_v & 8'hF0), 32'h0);

    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      exp_t x;
      x = exp_q.pop_front();
      if (x.at < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL %s: expectation for cyc %0d missed (now %0d)", x.name, x.at, cyc);
      end else begin
        check({x.name, ".ready"}, 32'(cmd_ready), 32'(x.rdy));
        check({x.name, ".out"},   32'(out_v),     32'(x.out));
        check({x.name, ".oe"},    32'(oe_v),      32'(x.oe));
        check({x.name, ".ie"},    32'(ie_v),      32'(x.ie));
        check({x.name, ".filt"},  32'(in_filt),   32'(x.filt));
      end
    end

    err_exp = (err_q.size() > 0 && err_q[0] == cyc);
    if (cmd_err || err_exp) begin
      check("cmd_err_pulse", 32'(cmd_err), 32'(err_exp));
      if (err_exp) void'(err_q.pop_front());
    end

    chg_exp = (chg_q.size() > 0 && chg_q[0].at == cyc) ? chg_q[0].val : 8'h00;
    if (in_chg != 8'h00 || chg_exp != 8'h00) begin
      check("in_chg_pulse", 32'(in_chg), 32'(chg_exp));
      if (chg_exp != 8'h00) void'(chg_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst_ni    = 1'b0;
    cmd_valid = 1'b0;
    cmd_pad   = 3'd0;
    cmd_oe    = 1'b0;
    cmd_out   = 1'b0;
    lock      = 8'h00;
    in_raw    = 8'h00;

    // Reset values, held and after release.
    repeat (2) @(negedge clk);
    expect_state(cyc + 1, "in_reset", 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00);
    @(negedge clk);
    rst_ni = 1'b1;
    expect_state(cyc + 1, "after_reset", 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00);
    repeat (2) @(negedge clk);

    // Input filter: a 10-cycle high on pad 7 passes after 2+4 cycles, and so
    // does the return to low. A 3-cycle glitch is swallowed.
    b = cyc;
    in_raw = 8'h80;
    expect_state(b + 5, "filt_pre_rise", 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00);
    expect_state(b + 6, "filt_rise",     1'b1, 8'h00, 8'h00, 8'hFF, 8'h80);
    expect_chg(b + 6, 8'h80);
    repeat (10) @(negedge clk);
    in_raw = 8'h00;
    expect_state(b + 15, "filt_pre_fall", 1'b1, 8'h00, 8'h00, 8'hFF, 8'h80);
    expect_state(b + 16, "filt_fall",     1'b1, 8'h00, 8'h00, 8'hFF, 8'h00);
    expect_chg(b + 16, 8'h80);
    repeat (10) @(negedge clk);
    in_raw = 8'h80;
    repeat (3) @(negedge clk);
    in_raw = 8'h00;
    expect_state(b + 30, "filt_glitch", 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00);
    repeat (8) @(negedge clk);

    // Input -> output on pad 2: out/ie settle, oe follows one cycle later.
    b = cyc;
    drive(3'd2, 1'b1, 1'b1);
    expect_state(b + 1, "oe_setup", 1'b0, 8'h04, 8'h00, 8'hFB, 8'h00);
    expect_state(b + 2, "oe_on",    1'b1, 8'h04, 8'h04, 8'hFB, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Output -> input on pad 2: ie stays low for TurnCycles cycles.
    b = cyc;
    drive(3'd2, 1'b0, 1'b0);
    expect_state(b + 1, "turn_1",  1'b0, 8'h04, 8'h00, 8'hFB, 8'h00);
    expect_state(b + 2, "turn_2",  1'b0, 8'h04, 8'h00, 8'hFB, 8'h00);
    expect_state(b + 3, "turn_ie", 1'b1, 8'h04, 8'h00, 8'hFF, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Drive request to input-only pad 5 is rejected. Then pad 2 becomes an
    // output and its value toggles back to back. A no-op follows last.
    b = cyc;
    drive(3'd5, 1'b1, 1'b1);
    err_q.push_back(b + 1);
    expect_state(b + 1, "reject_pad5", 1'b1, 8'h04, 8'h00, 8'hFF, 8'h00);
    @(negedge clk);
    drive(3'd2, 1'b1, 1'b0);
    expect_state(b + 2, "oe2_setup", 1'b0, 8'h00, 8'h00, 8'hFB, 8'h00);
    expect_state(b + 3, "oe2_on",    1'b1, 8'h00, 8'h04, 8'hFB, 8'h00);
    repeat (2) @(negedge clk);
    drive(3'd2, 1'b1, 1'b1);
    expect_state(b + 4, "toggle_1", 1'b1, 8'h04, 8'h04, 8'hFB, 8'h00);
    @(negedge clk);
    drive(3'd2, 1'b1, 1'b0);
    expect_state(b + 5, "toggle_0", 1'b1, 8'h00, 8'h04, 8'hFB, 8'h00);
    @(negedge clk);
    drive(3'd2, 1'b1, 1'b1);
    expect_state(b + 6, "toggle_1b", 1'b1, 8'h04, 8'h04, 8'hFB, 8'h00);
    @(negedge clk);
    drive(3'd3, 1'b0, 1'b0);
    expect_state(b + 7, "noop_pad3", 1'b1, 8'h04, 8'h04, 8'hFB, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);

    // Reset asserted in the middle of a turnaround.
    b = cyc;
    drive(3'd2, 1'b0, 1'b0);
    expect_state(b + 1, "pre_rst_turn", 1'b0, 8'h04, 8'h00, 8'hFB, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async.ready", 32'(cmd_ready), 32'h1);
    check("rst_async.out",   32'(out_v),     32'h00);
    check("rst_async.ie",    32'(ie_v),      32'hFF);
    expect_state(b + 2, "rst_mid_turn", 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    expect_state(b + 4, "rst_released", 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00);
    repeat (2) @(negedge clk);

`ifdef PAD_SLICE8_LOCK_EN
    // A locked pad takes the command, ignores it, and flags an error.
    b = cyc;
    lock = 8'h04;
    drive(3'd2, 1'b1, 1'b1);
    err_q.push_back(b + 1);
    expect_state(b + 1, "locked_pad2", 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    lock = 8'h00;
`endif

    repeat (4) @(negedge clk);
    #1;
    foreach (exp_q[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: never compared (cyc %0d)", exp_q[i].name, exp_q[i].at);
    end
    foreach (err_q[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_err_pulse: expected at cyc %0d, never seen", err_q[i]);
    end
    foreach (chg_q[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL in_chg_pulse: expected %0h at cyc %0d, never seen", chg_q[i].val, chg_q[i].at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
